// File: rtl/conv2d_frame_ctrl.sv
// conv2d_frame_ctrl
// Frame sequencer wrapped around a conv2d Sobel datapath. Clears the datapath
// at frame start, streams DEPTH_P x HEIGHT_P pixels into it, tags the accepts
// that complete a fully-populated 3x3 window and emits the matching gradients
// together with the window-centre coordinate, then drains and pulses done_o.
module conv2d_frame_ctrl #(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16,
    parameter int CW_P     = $clog2(DEPTH_P),
    parameter int RW_P     = $clog2(HEIGHT_P)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,

    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [WIDTH_P-1:0]          data_i,

    output logic                        conv_rstn_o,
    output logic                        conv_valid_o,
    input  logic                        conv_ready_i,
    output logic [WIDTH_P-1:0]          conv_data_o,
    input  logic signed [2*WIDTH_P-1:0] conv_gx_i,
    input  logic signed [2*WIDTH_P-1:0] conv_gy_i,

    output logic                        valid_o,
    output logic signed [2*WIDTH_P-1:0] gx_o,
    output logic signed [2*WIDTH_P-1:0] gy_o,
    output logic [CW_P-1:0]             col_o,
    output logic [RW_P-1:0]             row_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Number of drain cycles minus one; lets the last tagged window leave the
    // tag pipe before done_o.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    state_e                      state_q, state_d;
    logic [CW_P-1:0]             col_q, col_d;
    logic [RW_P-1:0]             row_q, row_d;
    logic [1:0]                  drain_q, drain_d;

    logic                        t1_q, t1_d;
    logic                        t2_q, t2_d;
    logic [CW_P-1:0]             c1_col_q, c1_col_d;
    logic [RW_P-1:0]             c1_row_q, c1_row_d;
    logic [CW_P-1:0]             c2_col_q, c2_col_d;
    logic [RW_P-1:0]             c2_row_q, c2_row_d;

    logic                        valid_q, valid_d;
    logic signed [2*WIDTH_P-1:0] gx_q, gx_d;
    logic signed [2*WIDTH_P-1:0] gy_q, gy_d;
    logic [CW_P-1:0]             col_out_q, col_out_d;
    logic [RW_P-1:0]             row_out_q, row_out_d;

    logic                        accept;
    logic                        col_last;
    logic                        row_last;
    logic                        tag;

    assign accept   = valid_i & ready_o;
    assign col_last = (col_q == CW_P'(DEPTH_P - 1));
    assign row_last = (row_q == RW_P'(HEIGHT_P - 1));
    // Window is complete only once two full rows and two columns precede it.
    assign tag      = accept & (row_q >= RW_P'(2)) & (col_q >= CW_P'(2));

    // State register: FSM state and frame counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic: frame sequencing and column/row/drain counting.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                col_d   = '0;
                row_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept) begin
                    if (col_last) begin
                        col_d = '0;
                        row_d = row_q + RW_P'(1);
                        if (row_last) begin
                            drain_d = '0;
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        col_d = col_q + CW_P'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: handshake gating, conv2d clear and status flags.
    always_comb begin
        busy_o       = (state_q != ST_IDLE);
        done_o       = (state_q == ST_DONE);
        ready_o      = conv_ready_i & (state_q == ST_RUN);
        conv_valid_o = valid_i & (state_q == ST_RUN);
        conv_data_o  = data_i;
        conv_rstn_o  = ~rst_i & (state_q != ST_CLEAR);
    end

    // Tag pipe and output capture: coordinates ride alongside the tag; the
    // gradients are sampled from conv2d when the tag reaches stage 2.
    always_comb begin
        t1_d      = tag;
        c1_col_d  = col_q - CW_P'(1);
        c1_row_d  = row_q - RW_P'(1);
        t2_d      = t1_q;
        c2_col_d  = c1_col_q;
        c2_row_d  = c1_row_q;
        valid_d   = t2_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        col_out_d = col_out_q;
        row_out_d = row_out_q;
        if (t2_q) begin
            gx_d      = conv_gx_i;
            gy_d      = conv_gy_i;
            col_out_d = c2_col_q;
            row_out_d = c2_row_q;
        end
    end

    // Pipeline and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            t1_q      <= 1'b0;
            t2_q      <= 1'b0;
            c1_col_q  <= '0;
            c1_row_q  <= '0;
            c2_col_q  <= '0;
            c2_row_q  <= '0;
            valid_q   <= 1'b0;
            gx_q      <= '0;
            gy_q      <= '0;
            col_out_q <= '0;
            row_out_q <= '0;
        end else begin
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            c1_col_q  <= c1_col_d;
            c1_row_q  <= c1_row_d;
            c2_col_q  <= c2_col_d;
            c2_row_q  <= c2_row_d;
            valid_q   <= valid_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            col_out_q <= col_out_d;
            row_out_q <= row_out_d;
        end
    end

    assign valid_o = valid_q;
    assign gx_o    = gx_q;
    assign gy_o    = gy_q;
    assign col_o   = col_out_q;
    assign row_o   = row_out_q;

endmodule

// File: tb/tb_conv2d_frame_ctrl.sv
// Bench for conv2d_frame_ctrl. The conv2d side is emulated by driving fresh
// random gradients every cycle; the reference model tracks the frame as a
// pixel index and schedules expected outputs in a queue by due cycle.
module tb_conv2d_frame_ctrl;

    localparam int W = 8;
    localparam int D = 4;
    localparam int H = 4;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic                  start_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  valid_i;
    logic                  ready_o;
    logic [W-1:0]          data_i;
    logic                  conv_rstn_o;
    logic                  conv_valid_o;
    logic                  conv_ready_i;
    logic [W-1:0]          conv_data_o;
    logic signed [2*W-1:0] conv_gx_i;
    logic signed [2*W-1:0] conv_gy_i;
    logic                  valid_o;
    logic signed [2*W-1:0] gx_o;
    logic signed [2*W-1:0] gy_o;
    logic [1:0]            col_o;
    logic [1:0]            row_o;

    always #5 clk = ~clk;

    conv2d_frame_ctrl #(
        .WIDTH_P (W),
        .DEPTH_P (D),
        .HEIGHT_P(H)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .conv_rstn_o (conv_rstn_o),
        .conv_valid_o(conv_valid_o),
        .conv_ready_i(conv_ready_i),
        .conv_data_o (conv_data_o),
        .conv_gx_i   (conv_gx_i),
        .conv_gy_i   (conv_gy_i),
        .valid_o     (valid_o),
        .gx_o        (gx_o),
        .gy_o        (gy_o),
        .col_o       (col_o),
        .row_o       (row_o)
    );

    typedef struct {
        int due;
        int col;
        int row;
    } exp_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_phase = P_IDLE;
    int          m_pix   = 0;
    int          m_drain = 0;
    int          cyc_n   = 0;
    logic        m_valid = 1'b0;
    logic [15:0] m_gx    = '0;
    logic [15:0] m_gy    = '0;
    int          m_col   = 0;
    int          m_row   = 0;
    int          frame_valid_cnt = 0;
    exp_t        q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cyc(input bit r, input bit s, input bit v, input bit rdy);
        logic [15:0] gx;
        logic [15:0] gy;
        exp_t        e;
        int          c;
        int          rw;
        rst_i        = r;
        start_i      = s;
        valid_i      = v;
        data_i       = W'($urandom);
        conv_ready_i = rdy;
        gx           = 16'($urandom);
        gy           = 16'($urandom);
        conv_gx_i    = gx;
        conv_gy_i    = gy;
        #1;
        chk("busy",       32'(busy_o),       32'(m_phase != P_IDLE));
        chk("done",       32'(done_o),       32'(m_phase == P_DONE));
        chk("ready",      32'(ready_o),      32'(rdy && m_phase == P_RUN));
        chk("conv_valid", 32'(conv_valid_o), 32'(v && m_phase == P_RUN));
        chk("conv_rstn",  32'(conv_rstn_o),  32'(!r && m_phase != P_CLEAR));
        chk("conv_data",  32'(conv_data_o),  32'(data_i));
        chk("valid_o",    32'(valid_o),      32'(m_valid));
        chk("gx",         {16'h0, gx_o},     {16'h0, m_gx});
        chk("gy",         {16'h0, gy_o},     {16'h0, m_gy});
        chk("col",        32'(col_o),        m_col);
        chk("row",        32'(row_o),        m_row);
        if (valid_o === 1'b1) frame_valid_cnt++;
        if (m_phase == P_DONE) chk("out_count", frame_valid_cnt, (D-2)*(H-2));

        if (r) begin
            m_phase = P_IDLE;
            m_valid = 1'b0;
            m_gx    = '0;
            m_gy    = '0;
            m_col   = 0;
            m_row   = 0;
            q.delete();
        end else begin
            if (q.size() > 0 && q[0].due == cyc_n) begin
                e       = q.pop_front();
                m_valid = 1'b1;
                m_gx    = gx;
                m_gy    = gy;
                m_col   = e.col;
                m_row   = e.row;
            end else begin
                m_valid = 1'b0;
            end
            case (m_phase)
                P_IDLE:  if (s) m_phase = P_CLEAR;
                P_CLEAR: begin
                    m_pix   = 0;
                    m_phase = P_RUN;
                end
                P_RUN: begin
                    if (v && rdy) begin
                        c  = m_pix % D;
                        rw = m_pix / D;
                        if (c >= 2 && rw >= 2) q.push_back('{cyc_n + 2, c - 1, rw - 1});
                        m_pix++;
                        if (m_pix == D*H) begin
                            m_drain = 0;
                            m_phase = P_DRAIN;
                        end
                    end
                end
                P_DRAIN: begin
                    m_drain++;
                    if (m_drain == 3) m_phase = P_DONE;
                end
                default: m_phase = P_IDLE;
            endcase
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    // Start a frame and run it until the model returns to idle.
    task automatic run_frame(input int gap_pct, input bit do_stall,
                             input int rst_pix, input int start_pix);
        int budget     = 0;
        int stall_left = 5;
        bit rst_done   = 1'b0;
        bit st_done    = 1'b0;
        bit r;
        bit s;
        bit v;
        bit rdy;
        frame_valid_cnt = 0;
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        while (m_phase != P_IDLE && budget < 400) begin
            r   = 1'b0;
            s   = 1'b0;
            v   = ($urandom_range(0, 99) >= gap_pct);
            rdy = 1'b1;
            if (do_stall && m_phase == P_RUN && m_pix == 2*D + 1 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            if (rst_pix >= 0 && !rst_done && m_phase == P_RUN && m_pix == rst_pix) begin
                r        = 1'b1;
                rst_done = 1'b1;
            end
            if (start_pix >= 0 && !st_done && m_pix == start_pix) begin
                s       = 1'b1;
                st_done = 1'b1;
            end
            cyc(r, s, v, rdy);
            budget++;
        end
        chk("frame_end_in_budget", 32'(budget < 400), 32'd1);
    endtask

    initial begin
        rst_i        = 1'b1;
        start_i      = 1'b0;
        valid_i      = 1'b0;
        data_i       = '0;
        conv_ready_i = 1'b1;
        conv_gx_i    = '0;
        conv_gy_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 1'b0, 1'b1);

        // idle with valid_i held high: nothing consumed
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1);

        // frame 1: valid tied high, stray start mid-frame
        run_frame(0, 1'b0, -1, 5);
        // frame 2 back-to-back: random gaps plus a 5-cycle stall in row 2
        run_frame(30, 1'b1, -1, -1);
        // frame 3: reset mid-row 2 abandons the frame
        run_frame(20, 1'b0, 2*D + 1, -1);
        // start together with reset: reset wins
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        // frame 4: full frame after the abandoned one
        run_frame(10, 1'b0, -1, -1);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
